// File: rtl/aes_job_queue_if.sv
// Host and cipher-side bundle for aes_job_queue: job push, core load/done, result valid/ready, status.
// The tag signals exist only when AES_JOB_TAG_EN is defined.
interface aes_job_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 128,
    parameter int KW    = 128
`ifdef AES_JOB_TAG_EN
    ,
    parameter int TAG_W = 4
`endif
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_text;
    logic [KW-1:0] in_key;
    logic          core_ld;
    logic [DW-1:0] core_text;
    logic [KW-1:0] core_key;
    logic          core_done;
    logic [DW-1:0] core_text_out;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_text;
    logic [LW-1:0] level;
    logic          busy;
`ifdef AES_JOB_TAG_EN
    logic [TAG_W-1:0] in_tag;
    logic [TAG_W-1:0] out_tag;
`endif

    modport slave (
`ifdef AES_JOB_TAG_EN
        input  in_tag,
        output out_tag,
`endif
        input  flush, in_valid, in_text, in_key, core_done, core_text_out, out_ready,
        output in_ready, core_ld, core_text, core_key, out_valid, out_text, level, busy
    );

    modport master (
`ifdef AES_JOB_TAG_EN
        output in_tag,
        input  out_tag,
`endif
        output flush, in_valid, in_text, in_key, core_done, core_text_out, out_ready,
        input  in_ready, core_ld, core_text, core_key, out_valid, out_text, level, busy
    );
endinterface

// File: rtl/aes_job_queue.sv
// DEPTH-entry {text,key} job FIFO feeding one AES core; push->core_ld 2 cycles, result registered 1 cycle after core_done.
// in_ready = !full; no dispatch unless the result register is free or draining. AES_JOB_TAG_EN adds a per-job tag.
module aes_job_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 128,
    parameter int KW    = 128,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    aes_job_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W < 1) begin : g_param_check
        $error("aes_job_queue: DEPTH must be a power of two >= 2 and TAG_W >= 1");
    end

    typedef struct packed {
`ifdef AES_JOB_TAG_EN
        logic [TAG_W-1:0] tag;
`endif
        logic [KW-1:0]    key;
        logic [DW-1:0]    text;
    } job_t;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

    job_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    state_t        r_state;
    logic          r_core_ld;
    logic [DW-1:0] r_core_text;
    logic [KW-1:0] r_core_key;
    logic          r_drop;
    logic          r_out_valid;
    logic [DW-1:0] r_out_text;
`ifdef AES_JOB_TAG_EN
    logic [TAG_W-1:0] r_fly_tag;
    logic [TAG_W-1:0] r_out_tag;
`endif

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_capture;
    job_t w_in_job;
    job_t w_head;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_push    = bus.in_valid && !w_full && !bus.flush;
    // Dispatch only if the result slot will be free when done arrives.
    assign w_pop     = (r_state == S_IDLE) && (r_level != '0) &&
                       (!r_out_valid || bus.out_ready) && !bus.flush;
    assign w_capture = (r_state == S_WAIT) && bus.core_done && !r_drop && !bus.flush;
    assign w_head    = r_mem[r_rd_ptr];

    always_comb begin
        w_in_job      = '0;
        w_in_job.text = bus.in_text;
        w_in_job.key  = bus.in_key;
`ifdef AES_JOB_TAG_EN
        w_in_job.tag  = bus.in_tag;
`endif
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_job;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_core_ld   <= 1'b0;
            r_core_text <= '0;
            r_core_key  <= '0;
            r_drop      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_text  <= '0;
`ifdef AES_JOB_TAG_EN
            r_fly_tag   <= '0;
            r_out_tag   <= '0;
`endif
        end else begin
            r_core_ld <= 1'b0;

            if (bus.flush)                          r_out_valid <= 1'b0;
            else if (w_capture)                     r_out_valid <= 1'b1;
            else if (r_out_valid && bus.out_ready)  r_out_valid <= 1'b0;

            if (w_capture) begin
                r_out_text <= bus.core_text_out;
`ifdef AES_JOB_TAG_EN
                r_out_tag  <= r_fly_tag;
`endif
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_core_text <= w_head.text;
                        r_core_key  <= w_head.key;
`ifdef AES_JOB_TAG_EN
                        r_fly_tag   <= w_head.tag;
`endif
                        r_core_ld   <= 1'b1;
                        r_drop      <= 1'b0;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.flush) r_drop <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A flushed job still owns the core until its done pulse.
                    if (bus.core_done) begin
                        r_drop  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (bus.flush) begin
                        r_drop  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.core_ld   = r_core_ld;
    assign bus.core_text = r_core_text;
    assign bus.core_key  = r_core_key;
    assign bus.out_valid = r_out_valid;
    assign bus.out_text  = r_out_text;
    assign bus.level     = r_level;
    assign bus.busy      = (r_state != S_IDLE);
`ifdef AES_JOB_TAG_EN
    assign bus.out_tag   = r_out_tag;
`endif
endmodule

// File: tb/tb_aes_job_queue.sv
// Directed bench for aes_job_queue with a behavioural cipher stand-in (12-cycle latency, stallable).
`timescale 1ns/1ps
module tb_aes_job_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 128;
    localparam int KW    = 128;
    localparam int TAG_W = 4;

    localparam logic [127:0] VEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] VEC_TXT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    aes_job_queue_if #(.DEPTH(DEPTH), .DW(DW), .KW(KW)
`ifdef AES_JOB_TAG_EN
        , .TAG_W(TAG_W)
`endif
    ) bus ();

    aes_job_queue #(.DEPTH(DEPTH), .DW(DW), .KW(KW), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bit            core_stall  = 1'b0;
    bit            core_inject = 1'b0;
    int            core_cnt    = 0;
    logic [DW-1:0] core_lt     = '0;
    logic [KW-1:0] core_lk     = '0;
    logic [127:0]  exp_q[$];
    logic [3:0]    tag_q[$];

    function automatic logic [DW-1:0] cipher(input logic [DW-1:0] t, input logic [KW-1:0] k);
        if (t == VEC_TXT && k == VEC_KEY) return VEC_CT;
        return t ^ k;
    endfunction

    initial begin
        bus.core_done     = 1'b0;
        bus.core_text_out = '0;
        forever begin
            @(posedge clk); #1;
            bus.core_done = 1'b0;
            if (!rst) begin
                core_cnt = 0;
            end else if (core_inject) begin
                bus.core_done     = 1'b1;
                bus.core_text_out = '1;
                core_inject       = 1'b0;
            end else if (bus.core_ld) begin
                core_cnt = 12;
                core_lt  = bus.core_text;
                core_lk  = bus.core_key;
            end else if (core_cnt > 1) begin
                core_cnt--;
            end else if (core_cnt == 1 && !core_stall) begin
                core_cnt          = 0;
                bus.core_done     = 1'b1;
                bus.core_text_out = cipher(core_lt, core_lk);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push_job(input logic [DW-1:0] t, input logic [KW-1:0] k, input logic [3:0] tg);
        bus.in_valid = 1'b1;
        bus.in_text  = t;
        bus.in_key   = k;
`ifdef AES_JOB_TAG_EN
        bus.in_tag   = tg;
`endif
        for (int i = 0; i < 200 && !bus.in_ready; i++) tick();
        check("push_rdy", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        exp_q.push_back(cipher(t, k));
        tag_q.push_back(tg);
    endtask

    task automatic wait_out(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(tag, ok, 1);
    endtask

    task automatic collect(input int n);
        for (int r = 0; r < n; r++) begin
            wait_out("res_vld");
            check("res_dat", bus.out_text, exp_q.size() > 0 ? exp_q.pop_front() : 128'hx);
`ifdef AES_JOB_TAG_EN
            check("res_tag", bus.out_tag, tag_q.size() > 0 ? tag_q.pop_front() : 4'hx);
`else
            if (tag_q.size() > 0) tag_q.delete(0);
`endif
            tick();
        end
    endtask

    function automatic logic [127:0] jt(input int i);
        return {4{32'hA500_0000 + i}};
    endfunction

    function automatic logic [127:0] jk(input int i);
        return {4{32'h0F0F_1000 + i * 3}};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        bit stable;
        bit bad;
        bit seen;
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_text   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
`ifdef AES_JOB_TAG_EN
        bus.in_tag    = '0;
`endif
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_core_ld", bus.core_ld, 0);
        check("rst_core_text", bus.core_text, 0);
        check("rst_core_key", bus.core_key, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_text", bus.out_text, 0);
        check("rst_level", bus.level, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Single known-answer job
        push_job(VEC_TXT, VEC_KEY, 4'h1);
        check("t1_level1", bus.level, 1);
        check("t1_no_ld_yet", bus.core_ld, 0);
        tick();
        check("t1_core_ld", bus.core_ld, 1);
        check("t1_core_text", bus.core_text, VEC_TXT);
        check("t1_core_key", bus.core_key, VEC_KEY);
        check("t1_level0", bus.level, 0);
        check("t1_busy", bus.busy, 1);
        bus.out_ready = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 40 && !bus.out_valid; i++) begin
            tick();
            if (bus.core_text !== VEC_TXT || bus.core_key !== VEC_KEY) stable = 1'b0;
        end
        check("t1_core_stable", stable, 1);
        collect(1);
        check("t1_level_end", bus.level, 0);
        check("t1_busy_end", bus.busy, 0);

        // Done pulse while idle must be ignored
        core_inject = 1'b1;
        tick(3);
        check("spurious_done", bus.out_valid, 0);

        // Fill with the core stalled, then drain
        core_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_job(jt(i), jk(i), 4'(i));
        check("fill_level3", bus.level, 3);
        check("fill_rdy3", bus.in_ready, 1);
        push_job(jt(4), jk(4), 4'h4);
        check("fill_level4", bus.level, 4);
        check("fill_rdy4", bus.in_ready, 0);
        check("fill_inflight", bus.core_text, jt(0));
        bus.in_valid = 1'b1;
        bus.in_text  = jt(99);
        tick(2);
        bus.in_valid = 1'b0;
        check("full_no_push", bus.level, 4);
        core_stall = 1'b0;
        collect(5);
        for (int p = 0; p < 2; p++) begin
            core_stall = 1'b1;
            for (int i = 0; i < 4; i++) push_job(jt(10 + p * 4 + i), jk(20 + p * 4 + i), 4'(i + 8));
            check("wrap_level", bus.level, 3);
            core_stall = 1'b0;
            collect(4);
        end

        // Back-pressure: second job must wait for the first result to be taken
        bus.out_ready = 1'b0;
        push_job(jt(40), jk(40), 4'h2);
        push_job(jt(41), jk(41), 4'h5);
        wait_out("bp_first_vld");
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_text !== cipher(jt(40), jk(40)) || bus.core_ld || !bus.out_valid || bus.level != 1)
                bad = 1'b1;
        end
        check("bp_hold", bad, 0);
        bus.out_ready = 1'b1;
        collect(2);

        // Push and pop on the same edge at level 2
        bus.out_ready = 1'b0;
        push_job(jt(50), jk(50), 4'h0);
        wait_out("pp_p0_vld");
        push_job(jt(51), jk(51), 4'h1);
        push_job(jt(52), jk(52), 4'h2);
        check("pp_level2", bus.level, 2);
        check("pp_idle", bus.busy, 0);
        bus.in_valid  = 1'b1;
        bus.in_text   = jt(53);
        bus.in_key    = jk(53);
`ifdef AES_JOB_TAG_EN
        bus.in_tag    = 4'h3;
`endif
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        exp_q.push_back(cipher(jt(53), jk(53)));
        tag_q.push_back(4'h3);
        exp_q.delete(0);
        tag_q.delete(0);
        check("pp_level_same", bus.level, 2);
        check("pp_core_ld", bus.core_ld, 1);
        check("pp_head", bus.core_text, jt(51));
        collect(3);

        // Flush while a job is in WAIT with 3 queued
        core_stall = 1'b1;
        for (int i = 0; i < 4; i++) push_job(jt(60 + i), jk(60 + i), 4'(i));
        check("fl_level3", bus.level, 3);
        check("fl_busy", bus.busy, 1);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_text  = jt(70);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        tag_q.delete();
        check("fl_level0", bus.level, 0);
        check("fl_still_busy", bus.busy, 1);
        core_stall = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("fl_no_result", seen, 0);
        check("fl_idle", bus.busy, 0);
        push_job(jt(71), jk(71), 4'h9);
        collect(1);

        // Asynchronous reset between edges while waiting on the core
        core_stall = 1'b1;
        push_job(jt(80), jk(80), 4'h0);
        push_job(jt(81), jk(81), 4'h0);
        tick();
        check("ar_busy", bus.busy, 1);
        #3;
        rst = 1'b0;
        #1;
        check("ar_busy0", bus.busy, 0);
        check("ar_core_ld", bus.core_ld, 0);
        check("ar_core_text", bus.core_text, 0);
        check("ar_core_key", bus.core_key, 0);
        check("ar_out_valid", bus.out_valid, 0);
        check("ar_level", bus.level, 0);
        check("ar_in_ready", bus.in_ready, 1);
        exp_q.delete();
        tag_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        core_stall = 1'b0;
        tick();
        push_job(jt(90), jk(90), 4'h3);
        push_job(jt(91), jk(91), 4'h7);
        push_job(jt(92), jk(92), 4'hA);
        collect(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/aes_job_queue.md
Name: aes_job_queue

Overview:
Parametrised successor to the single-entry AES input buffer: a DEPTH-entry FIFO of {text, key} jobs that sits between the testbench/host interface and aes_cipher_top. It dispatches one job at a time to the core with a one-cycle load pulse and holds the core inputs stable until done. It captures each core result into a valid/ready output register, so the host sees back-pressured, in-order results.

Parameters:
DEPTH, 4, job FIFO entries; power of two, >= 2
DW, 128, text/result width
KW, 128, key width
TAG_W, 4, job tag width (used only with AES_JOB_TAG_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
flush  in  1  sync clear of queued jobs and pending result
in_valid  in  1  job offered
in_ready  out  1  queue not full
in_text  in  DW  plaintext
in_key  in  KW  key
in_tag  in  TAG_W  job tag (AES_JOB_TAG_EN only)
core_ld  out  1  one-cycle load pulse to cipher
core_text  out  DW  registered text to cipher
core_key  out  KW  registered key to cipher
core_done  in  1  one-cycle done pulse from cipher
core_text_out  in  DW  cipher result, valid with core_done
out_valid  out  1  result available
out_ready  in  1  host accepts result
out_text  out  DW  result
out_tag  out  TAG_W  tag of result (AES_JOB_TAG_EN only)
level  out  $clog2(DEPTH+1)  queued job count (excludes in-flight job)
busy  out  1  job in flight (state LOAD or WAIT)

Behaviour:
- Reset (rst=0, async): FIFO pointers/level=0, state IDLE; in_ready=1, core_ld=0, core_text=0, core_key=0, out_valid=0, out_text=0, out_tag=0, busy=0.
- Push: in_valid & in_ready. in_ready = !full, derived from registers; no same-cycle bypass when full.
- Pop and push in the same cycle: level unchanged; both pointers advance and wrap modulo DEPTH.
- FSM:
  - IDLE -> LOAD when level>0 and (out_valid=0 or out_ready=1). The output slot must be free by the time done arrives.
  - LOAD (1 cycle): core_ld=1. core_text/core_key are registered from the head entry in the same edge that enters LOAD, then the head is popped. -> WAIT.
  - WAIT: core_text/core_key held stable. On core_done: out_text<=core_text_out, out_valid<=1 (tag from in-flight job) -> IDLE.
- Earliest next dispatch is the cycle after done. Min latency from push into an empty queue to core_ld: 2 cycles.
- Output: out_valid clears on out_valid & out_ready. out_text/out_tag hold while out_valid=1 and !out_ready.
- core_done outside WAIT is ignored.
- flush:
  - Level becomes 0 and out_valid becomes 0 next cycle.
  - If flush occurs in LOAD or WAIT, the job's result is discarded: a drop flag is set and the capture on core_done is suppressed. The FSM still waits for done before returning to IDLE.
  - A push in the flush cycle is discarded.
- Reset mid-WAIT: returns to IDLE and the job is lost. The core is reset by the same rst.

Optional Feature:
AES_JOB_TAG_EN
- Defined: in_tag is stored per entry, carried through the in-flight register, and presented on out_tag with the result.
- Not defined: in_tag/out_tag ports are absent and no tag storage is built.

Test Plan:
- Single job: push key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff; model core returns 69c4e0d86a7b0430d8cdb78070b4c55a after 12 cycles -> core_ld 2 cycles after push, core_text/key stable through WAIT, out_valid=1 with that value, level back to 0.
- Fill: push 5 jobs with DEPTH=4 while the core is stalled (no done) -> first job dispatched; in_ready=0 only when level=4; wrap-around verified over 3 full passes.
- Back-pressure: out_ready=0 for 20 cycles with 2 jobs queued -> second core_ld not issued until the first result is accepted; out_text stable throughout; results arrive in order.
- Simultaneous push/pop at level=2 -> level stays 2, pointers advance.
- flush during WAIT with 3 jobs queued -> level=0 next cycle; core_done result not presented (out_valid stays 0); FSM returns to IDLE after done; new job afterwards processes normally.
- Async reset asserted mid-WAIT between clock edges -> all outputs to reset values immediately; with AES_JOB_TAG_EN, tags 3,7,A return in order on out_tag.
